// File: rtl/uart_command_coordinator.sv
// Host-command front end: decodes single-letter UART commands with payloads into the LED,
// distance, gate-matrix and gate-length registers, and streams them back on 'C'.
module uart_command_coordinator #(
    parameter int NUMBER_BITS   = 37,
    parameter int NUMBER_BYTES  = 5,
    parameter int DISTANCE_BITS = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] received_byte,
    input  logic       received_ready,
    output logic [7:0] transmit_byte,
    input  logic       transmit_available,
    output logic       transmit_ready,
    output logic [7:0] green_leds
);
    localparam int WIRE_BITS = 8 * NUMBER_BYTES;
    localparam int LOW_BITS  = 8 * (NUMBER_BYTES - 1);
    localparam int TOP_BITS  = NUMBER_BITS - LOW_BITS;

    localparam logic [2:0] LAST_BYTE  = 3'(NUMBER_BYTES - 1);
    localparam logic [2:0] LAST_NUM   = 3'd7;
    localparam logic [5:0] TX_MTX_END = 6'(8 * NUMBER_BYTES);
    localparam logic [5:0] TX_LAST    = 6'(8 * NUMBER_BYTES + DISTANCE_BITS / 8);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_LED  = 3'd1;
    localparam logic [2:0] GET_DIST = 3'd2;
    localparam logic [2:0] GET_MTX  = 3'd3;
    localparam logic [2:0] GET_GLEN = 3'd4;
    localparam logic [2:0] SEND     = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [7:0]               leds_q, leds_d;
    logic [DISTANCE_BITS-1:0] dist_q, dist_d;
    logic [7:0]               glen_q, glen_d;
    logic [NUMBER_BITS-1:0]   mtx_q [8];
    logic [NUMBER_BITS-1:0]   mtx_d [8];
    logic [LOW_BITS-1:0]      asm_q, asm_d;
    logic [2:0]               bidx_q, bidx_d;
    logic [2:0]               nidx_q, nidx_d;
    logic [5:0]               txcnt_q, txcnt_d;
    logic [7:0]               txb_q, txb_d;
    logic                     txr_q, txr_d;
    logic                     guard_q, guard_d;

    logic [5:0]             bsel;
    logic [NUMBER_BITS-1:0] rx_elem;
    logic [NUMBER_BITS-1:0] tx_elem;
    logic [WIRE_BITS-1:0]   tx_word;
    logic [7:0]             tx_sel;

    assign bsel    = {bidx_q, 3'b000};
    // Earlier bytes of a number sit in asm_q; the last byte only contributes its low bits.
    assign rx_elem = {received_byte[TOP_BITS-1:0], asm_q};
    assign tx_elem = mtx_q[nidx_q];
    assign tx_word = {{(WIRE_BITS - NUMBER_BITS){tx_elem[NUMBER_BITS-1]}}, tx_elem};

    always_comb begin
        tx_sel = glen_q;
        if (txcnt_q < TX_MTX_END)
            tx_sel = tx_word[bsel +: 8];
        else if (txcnt_q < TX_LAST)
            tx_sel = dist_q[bsel +: 8];
    end

    always_comb begin
        state_d = state_q;
        leds_d  = leds_q;
        dist_d  = dist_q;
        glen_d  = glen_q;
        mtx_d   = mtx_q;
        asm_d   = asm_q;
        bidx_d  = bidx_q;
        nidx_d  = nidx_q;
        txcnt_d = txcnt_q;
        txb_d   = txb_q;
        txr_d   = 1'b0;
        // The cycle after a pulse is a guard cycle: the transmitter's available is stale there.
        guard_d = txr_q;

        case (state_q)
            IDLE: begin
                if (received_ready) begin
                    case (received_byte)
                        8'h4C:   state_d = GET_LED;
                        8'h44:   state_d = GET_DIST;
                        8'h4D:   state_d = GET_MTX;
                        8'h47:   state_d = GET_GLEN;
                        8'h43:   state_d = SEND;
                        default: state_d = IDLE;
                    endcase
                end
            end
            GET_LED: begin
                if (received_ready) begin
                    leds_d  = received_byte;
                    state_d = IDLE;
                end
            end
            GET_DIST: begin
                if (received_ready) begin
                    dist_d[bsel +: 8] = received_byte;
                    if (bidx_q == LAST_BYTE) begin
                        bidx_d  = 3'd0;
                        state_d = IDLE;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end
            GET_MTX: begin
                if (received_ready) begin
                    if (bidx_q == LAST_BYTE) begin
                        mtx_d[nidx_q] = rx_elem;
                        bidx_d        = 3'd0;
                        if (nidx_q == LAST_NUM) begin
                            nidx_d  = 3'd0;
                            state_d = IDLE;
                        end else begin
                            nidx_d = nidx_q + 3'd1;
                        end
                    end else begin
                        asm_d  = {received_byte, asm_q[LOW_BITS-1:8]};
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end
            GET_GLEN: begin
                if (received_ready) begin
                    glen_d  = received_byte;
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (!txr_q && !guard_q && transmit_available) begin
                    txb_d = tx_sel;
                    txr_d = 1'b1;
                    if (bidx_q == LAST_BYTE) begin
                        bidx_d = 3'd0;
                        if (txcnt_q < TX_MTX_END)
                            nidx_d = nidx_q + 3'd1;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                    if (txcnt_q == TX_LAST) begin
                        txcnt_d = 6'd0;
                        bidx_d  = 3'd0;
                        nidx_d  = 3'd0;
                        state_d = IDLE;
                    end else begin
                        txcnt_d = txcnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            leds_q  <= '0;
            dist_q  <= '0;
            glen_q  <= '0;
            for (int i = 0; i < 8; i++) mtx_q[i] <= '0;
            asm_q   <= '0;
            bidx_q  <= '0;
            nidx_q  <= '0;
            txcnt_q <= '0;
            txb_q   <= '0;
            txr_q   <= 1'b0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            dist_q  <= dist_d;
            glen_q  <= glen_d;
            mtx_q   <= mtx_d;
            asm_q   <= asm_d;
            bidx_q  <= bidx_d;
            nidx_q  <= nidx_d;
            txcnt_q <= txcnt_d;
            txb_q   <= txb_d;
            txr_q   <= txr_d;
            guard_q <= guard_d;
        end
    end

    assign transmit_byte  = txb_q;
    assign transmit_ready = txr_q;
    assign green_leds     = leds_q;
endmodule

// File: tb/tb_uart_command_coordinator.sv
// Scoreboard bench: commands update a byte-level model; readback bytes are queued on 'C'
// and popped by a monitor on every transmit pulse; a busy transmitter model paces the link.
module tb_uart_command_coordinator;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] received_byte = 8'h00;
    logic       received_ready = 1'b0;
    logic [7:0] transmit_byte;
    logic       transmit_available;
    logic       transmit_ready;
    logic [7:0] green_leds;

    uart_command_coordinator dut (
        .clk                (clk),
        .reset              (reset),
        .received_byte      (received_byte),
        .received_ready     (received_ready),
        .transmit_byte      (transmit_byte),
        .transmit_available (transmit_available),
        .transmit_ready     (transmit_ready),
        .green_leds         (green_leds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state: what the host has written, as plain values.
    logic [7:0]  m_leds = 8'h00;
    logic [36:0] m_elem [8];
    logic [39:0] m_dist = 40'h0;
    logic [7:0]  m_glen = 8'h00;
    logic [39:0] stg [8];
    logic [7:0]  exp_q [$];

    // Transmitter: sees a pulse, keeps available high one more cycle, then busy 7 cycles.
    initial begin
        logic p;
        logic drop;
        int   busy;
        drop = 1'b0;
        busy = 0;
        transmit_available = 1'b1;
        forever begin
            @(negedge clk);
            p = transmit_ready;
            @(posedge clk);
            #1;
            if (drop) begin
                transmit_available = 1'b0;
                busy = 6;
                drop = 1'b0;
            end else if (busy > 0) begin
                busy--;
            end else begin
                transmit_available = 1'b1;
            end
            if (p) drop = 1'b1;
        end
    end

    // Monitor: every pulse pops one expected byte and is checked against the handshake rules.
    initial begin
        logic prev_rdy, prev2_rdy, prev_avail;
        logic [7:0] e;
        prev_rdy = 1'b0;
        prev2_rdy = 1'b0;
        prev_avail = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && transmit_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse got byte=%02h required=no pulse", transmit_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (transmit_byte !== e) begin
                        failures++;
                        $display("FAIL readback_byte got=%02h required=%02h", transmit_byte, e);
                    end
                end
                checks++;
                if (prev_rdy || prev2_rdy || !prev_avail) begin
                    failures++;
                    $display("FAIL tx_handshake prev_rdy=%0b prev2_rdy=%0b prev_avail=%0b required=0,0,1",
                             prev_rdy, prev2_rdy, prev_avail);
                end
            end
            prev2_rdy  = prev_rdy;
            prev_rdy   = reset ? transmit_ready : 1'b0;
            prev_avail = transmit_available;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [7:0] b);
        received_byte  = b;
        received_ready = 1'b1;
        tick();
        received_ready = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%02h required=%02h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_leds = 8'h00;
        m_dist = 40'h0;
        m_glen = 8'h00;
        for (int i = 0; i < 8; i++) m_elem[i] = 37'h0;
    endtask

    task automatic cmd_led(input logic [7:0] v);
        drv(8'h4C);
        drv(v);
        m_leds = v;
        check8("green_leds", green_leds, m_leds);
    endtask

    task automatic cmd_dist(input logic [39:0] d);
        drv(8'h44);
        for (int b = 0; b < 5; b++) drv(d[8*b +: 8]);
        m_dist = d;
    endtask

    // Sends the eight 40-bit wire numbers in stg; only their low 37 bits are kept.
    task automatic cmd_mtx();
        logic [39:0] w;
        drv(8'h4D);
        for (int n = 0; n < 8; n++) begin
            w = stg[n];
            for (int b = 0; b < 5; b++) drv(w[8*b +: 8]);
            m_elem[n] = w[36:0];
        end
    endtask

    task automatic cmd_glen(input logic [7:0] v);
        drv(8'h47);
        drv(v);
        m_glen = v;
    endtask

    task automatic cmd_send();
        logic [39:0] w;
        int n;
        for (int i = 0; i < 8; i++) begin
            w = {{3{m_elem[i][36]}}, m_elem[i]};
            for (int b = 0; b < 5; b++) exp_q.push_back(w[8*b +: 8]);
        end
        for (int b = 0; b < 5; b++) exp_q.push_back(m_dist[8*b +: 8]);
        exp_q.push_back(m_glen);
        drv(8'h43);
        // Bytes arriving during the readback must be dropped.
        repeat ($urandom_range(1, 4)) drv(8'($urandom));
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL readback_drain remaining=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) tick();
    endtask

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'h4C || b == 8'h44 || b == 8'h4D || b == 8'h47 || b == 8'h43)
            b = 8'($urandom);
        return b;
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check8("reset_green_leds", green_leds, 8'h00);
        check8("reset_transmit_byte", transmit_byte, 8'h00);
        check8("reset_transmit_ready", {7'd0, transmit_ready}, 8'h00);
        reset = 1'b1;
        tick();

        cmd_send();
        cmd_led(8'h95);
        drv(8'h58);
        cmd_led(8'h5A);
        cmd_dist(40'h75782C528A);
        stg[0] = 40'd24296004000;
        stg[1] = 40'd0;
        stg[2] = 40'd24296004001;
        stg[3] = 40'd0;
        stg[4] = 40'd24296004002;
        stg[5] = 40'd0;
        stg[6] = 40'h0 - 40'd24296004003;
        stg[7] = 40'd0;
        cmd_mtx();
        cmd_glen(8'h03);
        cmd_send();

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0: cmd_led(8'($urandom));
                1: cmd_dist({8'($urandom), 32'($urandom)});
                2: begin
                    for (int n = 0; n < 8; n++) stg[n] = {8'($urandom), 32'($urandom)};
                    cmd_mtx();
                end
                3: cmd_glen(8'($urandom));
                4: drv(junk_byte());
                default: cmd_send();
            endcase
        end
        cmd_send();

        drv(8'h4D);
        for (int i = 0; i < 12; i++) drv(8'($urandom));
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check8("midcmd_reset_green_leds", green_leds, 8'h00);
        check8("midcmd_reset_transmit_byte", transmit_byte, 8'h00);
        check8("midcmd_reset_transmit_ready", {7'd0, transmit_ready}, 8'h00);
        reset = 1'b1;
        tick();
        cmd_led(8'h3C);
        cmd_send();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
